// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tank_pkg
//  Description : Shared sizing constants and types for the bullet scheduler.
//  Revision    : 1.0
// ============================================================================
package tank_pkg;

   localparam int NUM_SLOTS    = 8;
   localparam int MAX_PER_TANK = 4;
   localparam int COOLDOWN     = 15;
   localparam int LIFETIME     = 600;

   typedef logic [2:0] slot_idx_t;
   typedef logic       tank_id_t;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_FREEZE = 1'b1
   } state_e;

endpackage
`default_nettype wire

// File: rtl/bullet_slot.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_slot
//  Description : One bullet slot: busy/owner state and a lifetime counter.
//  Revision    : 1.0
// ============================================================================
module bullet_slot
   import tank_pkg::*;
#(
   parameter int LIFETIME = tank_pkg::LIFETIME
) (
   input  logic frame_clk,
   input  logic Reset_n,
   input  logic i_clear,
   input  logic i_grant,
   input  logic i_owner,
   input  logic i_free,
   output logic o_busy,
   output logic o_owner,
   output logic o_release,
   output logic o_expire
);

   logic       r_busy;
   logic       r_owner;
   logic       r_expire;
   logic [9:0] r_life;
   logic       w_timeout;
   logic       w_release;

   assign w_timeout = r_busy && (r_life == 10'(LIFETIME - 1));
   // A wall hit and a timeout in the same cycle release the slot only once.
   assign w_release = r_busy && (i_free || w_timeout);

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_busy   <= 1'b0;
         r_owner  <= 1'b0;
         r_expire <= 1'b0;
         r_life   <= '0;
      end else if (i_clear) begin
         r_busy   <= 1'b0;
         r_owner  <= 1'b0;
         r_expire <= 1'b0;
         r_life   <= '0;
      end else begin
         r_expire <= w_timeout;
         if (i_grant) begin
            r_busy  <= 1'b1;
            r_owner <= i_owner;
            r_life  <= '0;
         end else if (w_release) begin
            r_busy <= 1'b0;
            r_life <= '0;
         end else if (r_busy) begin
            r_life <= r_life + 10'd1;
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_owner   = r_owner;
   assign o_release = w_release;
   assign o_expire  = r_expire;

endmodule
`default_nettype wire

// File: rtl/bullet_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bullet_scheduler
//  Description : Arbitrates tank fire requests onto a shared pool of bullet slots.
//  Revision    : 1.0
// ============================================================================
module bullet_scheduler
   import tank_pkg::*;
#(
   parameter int NUM_SLOTS    = tank_pkg::NUM_SLOTS,
   parameter int MAX_PER_TANK = tank_pkg::MAX_PER_TANK,
   parameter int COOLDOWN     = tank_pkg::COOLDOWN,
   parameter int LIFETIME     = tank_pkg::LIFETIME
) (
   input  logic                 frame_clk,
   input  logic                 Reset_n,
   input  logic [1:0]           shoot_req,
   input  logic [1:0]           game_end,
   input  logic [NUM_SLOTS-1:0] slot_free,
   output logic                 launch_valid,
   output logic                 launch_tank,
   output logic [2:0]           launch_slot,
   output logic [NUM_SLOTS-1:0] slot_busy,
   output logic [NUM_SLOTS-1:0] slot_owner,
   output logic [NUM_SLOTS-1:0] slot_expire,
   output logic [1:0][2:0]      live_cnt
);

   localparam logic [0:0] c_ST_RUN    = ST_RUN;
   localparam logic [0:0] c_ST_FREEZE = ST_FREEZE;
   localparam int         c_CD_W      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
   localparam logic [c_CD_W-1:0] c_COOLDOWN = c_CD_W'(COOLDOWN);
   localparam logic [2:0]        c_MAX      = 3'(MAX_PER_TANK);

   logic [0:0]        r_state;
   logic [1:0]        r_shoot_prev;
   logic [1:0]        r_pending;
   logic [c_CD_W-1:0] r_cd [2];
   logic              r_rr;
   logic              r_launch_valid;
   tank_id_t          r_launch_tank;
   slot_idx_t         r_launch_slot;
   logic [1:0][2:0]   r_live_cnt;

   logic                 w_clear;
   logic [1:0]           w_rise;
   logic [1:0]           w_want;
   logic [1:0]           w_elig;
   logic [1:0]           w_inc;
   logic [c_CD_W-1:0]    w_cd_dec [2];
   logic [2:0]           w_cnt_next [2];
   logic [3:0]           w_rel_cnt [2];
   logic                 w_any_free;
   slot_idx_t            w_free_idx;
   logic                 w_grant;
   tank_id_t             w_win;
   logic [NUM_SLOTS-1:0] w_busy;
   logic [NUM_SLOTS-1:0] w_owner;
   logic [NUM_SLOTS-1:0] w_release;

   assign w_clear = (r_state == c_ST_FREEZE) || (game_end != 2'b00);
   assign w_rise  = shoot_req & ~r_shoot_prev;

   always_comb begin
      w_any_free = 1'b0;
      w_free_idx = '0;
      for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
         if (!w_busy[s]) begin
            w_any_free = 1'b1;
            w_free_idx = slot_idx_t'(s);
         end
      end
   end

   always_comb begin
      w_rel_cnt[0] = '0;
      w_rel_cnt[1] = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         if (w_release[s]) w_rel_cnt[w_owner[s]] = w_rel_cnt[w_owner[s]] + 4'd1;
      end
   end

   // Eligibility looks at the post-decrement cooldown, so the grant cycle counts as one frame.
   always_comb begin
      for (int t = 0; t < 2; t++) begin
         w_cd_dec[t] = (r_cd[t] == '0) ? '0 : r_cd[t] - 1'b1;
         w_want[t]   = r_pending[t] || (w_rise[t] && (r_live_cnt[t] != c_MAX));
         w_elig[t]   = w_want[t] && (w_cd_dec[t] == '0) && (r_live_cnt[t] != c_MAX)
                       && w_any_free && !w_clear;
      end
      w_grant = (w_elig != 2'b00);
      w_win   = (w_elig == 2'b11) ? r_rr : w_elig[1];
      for (int t = 0; t < 2; t++) begin
         w_inc[t]      = w_grant && (w_win == 1'(t));
         w_cnt_next[t] = 3'(4'(r_live_cnt[t]) + 4'(w_inc[t]) - w_rel_cnt[t]);
      end
   end

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state        <= c_ST_RUN;
         r_shoot_prev   <= '0;
         r_pending      <= '0;
         r_cd[0]        <= '0;
         r_cd[1]        <= '0;
         r_rr           <= 1'b0;
         r_launch_valid <= 1'b0;
         r_launch_tank  <= 1'b0;
         r_launch_slot  <= '0;
         r_live_cnt     <= '0;
      end else begin
         case (r_state)
            c_ST_RUN:    r_state <= (game_end != 2'b00) ? c_ST_FREEZE : c_ST_RUN;
            c_ST_FREEZE: r_state <= (game_end == 2'b00) ? c_ST_RUN : c_ST_FREEZE;
            default:     r_state <= c_ST_RUN;
         endcase
         r_shoot_prev   <= shoot_req;
         r_launch_valid <= w_grant;
         if (w_grant) begin
            r_launch_tank <= w_win;
            r_launch_slot <= w_free_idx;
            r_rr          <= ~w_win;
         end
         for (int t = 0; t < 2; t++) begin
            if (w_clear) begin
               r_pending[t]  <= 1'b0;
               r_cd[t]       <= '0;
               r_live_cnt[t] <= '0;
            end else begin
               r_pending[t]  <= w_want[t] && !w_inc[t];
               r_cd[t]       <= w_inc[t] ? c_COOLDOWN : w_cd_dec[t];
               r_live_cnt[t] <= w_cnt_next[t];
            end
         end
      end
   end

   generate
      for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
         bullet_slot #(
            .LIFETIME (LIFETIME)
         ) u_slot (
            .frame_clk (frame_clk),
            .Reset_n   (Reset_n),
            .i_clear   (w_clear),
            .i_grant   (w_grant && (w_free_idx == 3'(s))),
            .i_owner   (w_win),
            .i_free    (slot_free[s]),
            .o_busy    (w_busy[s]),
            .o_owner   (w_owner[s]),
            .o_release (w_release[s]),
            .o_expire  (slot_expire[s])
         );
      end
   endgenerate

   assign launch_valid = r_launch_valid;
   assign launch_tank  = r_launch_tank;
   assign launch_slot  = r_launch_slot;
   assign slot_busy    = w_busy;
   assign slot_owner   = w_owner;
   assign live_cnt     = r_live_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bullet_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bullet_scheduler
//  Description : Directed self-checking bench for bullet_scheduler.
//  Revision    : 1.0
// ============================================================================
module tb_bullet_scheduler;

   logic            frame_clk;
   logic            Reset_n;
   logic [1:0]      shoot_req;
   logic [1:0]      game_end;
   logic [7:0]      slot_free;
   logic            launch_valid;
   logic            launch_tank;
   logic [2:0]      launch_slot;
   logic [7:0]      slot_busy;
   logic [7:0]      slot_owner;
   logic [7:0]      slot_expire;
   logic [1:0][2:0] live_cnt;

   int n_checks = 0;
   int n_errors = 0;

   bullet_scheduler u_dut (
      .frame_clk    (frame_clk),
      .Reset_n      (Reset_n),
      .shoot_req    (shoot_req),
      .game_end     (game_end),
      .slot_free    (slot_free),
      .launch_valid (launch_valid),
      .launch_tank  (launch_tank),
      .launch_slot  (launch_slot),
      .slot_busy    (slot_busy),
      .slot_owner   (slot_owner),
      .slot_expire  (slot_expire),
      .live_cnt     (live_cnt)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge frame_clk);
   endtask

   // Reset asserted mid-flight: bullets vanish without expire pulses.
   task automatic do_reset();
      Reset_n = 1'b0;
      #1;
      chk("rst_busy", slot_busy, 0);
      chk("rst_expire", slot_expire, 0);
      chk("rst_cnt", live_cnt, 0);
      chk("rst_valid", launch_valid, 0);
      step(2);
      Reset_n = 1'b1;
      step(2);
   endtask

   task automatic shoot1_and_wait();
      shoot_req = 2'b01;
      step(1);
      chk("fill_launch", launch_valid, 1);
      shoot_req = 2'b00;
      step(20);
   endtask

   initial begin
      int n;
      int lat;
      int first;
      int pulses;
      logic [2:0] sl;
      logic       busy_at;
      logic [2:0] cnt_at;

      Reset_n   = 1'b0;
      shoot_req = 2'b00;
      game_end  = 2'b00;
      slot_free = '0;
      #3;
      chk("init_valid", launch_valid, 0);
      chk("init_busy", slot_busy, 0);
      chk("init_owner", slot_owner, 0);
      chk("init_cnt", live_cnt, 0);
      step(1);
      Reset_n = 1'b1;
      step(1);

      // single press, then held level gives no second launch
      shoot_req = 2'b01;
      step(1);
      chk("t1_valid", launch_valid, 1);
      chk("t1_tank", launch_tank, 0);
      chk("t1_slot", launch_slot, 0);
      chk("t1_busy", slot_busy, 8'h01);
      chk("t1_cnt", live_cnt[0], 1);
      n = 0;
      repeat (100) begin
         step(1);
         if (launch_valid) n++;
      end
      chk("hold_no_relaunch", n, 0);
      shoot_req = 2'b00;

      // simultaneous presses: tank1 first, tank2 next cycle
      do_reset();
      shoot_req = 2'b11;
      step(1);
      chk("both_first_valid", launch_valid, 1);
      chk("both_first_tank", launch_tank, 0);
      chk("both_first_slot", launch_slot, 0);
      step(1);
      chk("both_second_valid", launch_valid, 1);
      chk("both_second_tank", launch_tank, 1);
      chk("both_second_slot", launch_slot, 1);
      step(1);
      chk("both_third_idle", launch_valid, 0);
      chk("both_owner", slot_owner, 8'h02);
      chk("both_cnt0", live_cnt[0], 1);
      chk("both_cnt1", live_cnt[1], 1);
      shoot_req = 2'b00;

      // re-press during cooldown: launch 15 cycles after the first
      do_reset();
      shoot_req = 2'b01;
      step(1);
      chk("cd_first_valid", launch_valid, 1);
      shoot_req = 2'b00;
      step(4);
      shoot_req = 2'b01;
      lat = 0;
      sl  = 3'd7;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         if (launch_valid && lat == 0) begin
            lat = i;
            sl  = launch_slot;
         end
      end
      chk("cd_relaunch_cycle", lat, 11);
      chk("cd_relaunch_slot", sl, 1);
      shoot_req = 2'b00;

      // per-tank limit, drop, then free slot 2 and re-allocate it
      do_reset();
      repeat (4) shoot1_and_wait();
      chk("full_cnt", live_cnt[0], 4);
      chk("full_busy", slot_busy, 8'h0F);
      shoot_req = 2'b01;
      step(1);
      chk("full_no_launch", launch_valid, 0);
      shoot_req = 2'b00;
      n = 0;
      repeat (20) begin
         step(1);
         if (launch_valid) n++;
      end
      chk("full_req_dropped", n, 0);
      slot_free = 8'h80;
      step(1);
      slot_free = '0;
      chk("free_idle_ignored", live_cnt[0], 4);
      slot_free = 8'h04;
      step(1);
      slot_free = '0;
      chk("free2_cnt", live_cnt[0], 3);
      chk("free2_busy", slot_busy, 8'h0B);
      shoot_req = 2'b01;
      step(1);
      chk("realloc_valid", launch_valid, 1);
      chk("realloc_slot", launch_slot, 2);
      chk("realloc_cnt", live_cnt[0], 4);
      shoot_req = 2'b00;

      // lifetime expiry
      do_reset();
      shoot_req = 2'b01;
      step(1);
      chk("life_launch", launch_valid, 1);
      shoot_req = 2'b00;
      first   = 0;
      pulses  = 0;
      busy_at = 1'b1;
      cnt_at  = 3'd7;
      for (int i = 1; i <= 700; i++) begin
         step(1);
         if (slot_expire[0]) begin
            pulses++;
            if (first == 0) begin
               first   = i;
               busy_at = slot_busy[0];
               cnt_at  = live_cnt[0];
            end
         end
      end
      chk("life_expire_cycle", first, 600);
      chk("life_expire_pulses", pulses, 1);
      chk("life_busy_cleared", busy_at, 0);
      chk("life_cnt_dec", cnt_at, 0);

      // freeze clears everything and blocks presses
      do_reset();
      repeat (3) shoot1_and_wait();
      chk("frz_pre_cnt", live_cnt[0], 3);
      game_end = 2'b01;
      step(1);
      chk("frz_busy", slot_busy, 0);
      chk("frz_cnt", live_cnt[0], 0);
      shoot_req = 2'b01;
      n = 0;
      repeat (3) begin
         step(1);
         if (launch_valid) n++;
      end
      chk("frz_no_launch", n, 0);
      shoot_req = 2'b00;
      game_end  = 2'b00;
      step(1);
      chk("frz_exit_idle", launch_valid, 0);
      shoot_req = 2'b01;
      step(1);
      chk("resume_valid", launch_valid, 1);
      chk("resume_slot", launch_slot, 0);
      shoot_req = 2'b00;
      step(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
